// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with a small write FIFO.
// Frames are DATA_BITS data bits LSB first, an optional parity bit and
// STOP_BITS stop bits. Queued bytes go out back-to-back with no idle gap.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       asynchronous reset, active-high
//   trmt      push tx_data into the FIFO this cycle
//   tx_data   frame payload
//   ovf_clr   clears the sticky overflow flag
//   TX        serial line, idle high, driven from a flop
//   tx_done   one-cycle pulse on the final clock of each frame's last stop bit
//   busy      high while a frame is on the line
//   full      FIFO holds FIFO_DEPTH entries
//   count     entries waiting in the FIFO (excludes the frame in flight)
//   overflow  sticky: trmt seen while full
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 2605,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               trmt,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               ovf_clr,
  output logic                               TX,
  output logic                               tx_done,
  output logic                               busy,
  output logic                               full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               overflow
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(DATA_BITS+1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 4");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop, fifo_empty;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q;
  logic [NW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q, tx_d;
  logic                 baud_wrap, shift_en, bit_clr, bit_inc;

  // ---- FIFO write side / occupancy ----
  assign fifo_empty = (count == '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push       = trmt && !full;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new overflow event takes priority over the clear.
      if (trmt && full)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // ---- Frame sequencer: next state / line value ----
  assign baud_wrap = (baud_q == BW'(CLKS_PER_BIT-1));

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    tx_done  = 1'b0;
    shift_en = 1'b0;
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_d  = DATA;
          tx_d     = shift_q[0];
          shift_en = 1'b1;
          bit_clr  = 1'b1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_q == NW'(DATA_BITS-1)) begin
            bit_clr = 1'b1;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_inc  = 1'b1;
            tx_d     = shift_q[0];
            shift_en = 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_wrap) begin
          state_d = STOP;
          tx_d    = 1'b1;
          bit_clr = 1'b1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (bit_q == NW'(STOP_BITS-1)) begin
            tx_done = 1'b1;
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // ---- Frame sequencer: registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      if (state_q == IDLE || baud_wrap)
        baud_q <= '0;
      else
        baud_q <= baud_q + BW'(1);
      if (bit_clr)
        bit_q <= '0;
      else if (bit_inc)
        bit_q <= bit_q + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q <= mem[rd_ptr];
      par_q   <= calc_parity(mem[rd_ptr]);
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
    end
  end

  assign TX   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       trmt;
  logic       ovf_clr;
  logic [7:0] tx_data;

  // index: 0=8N1 1=8E1 2=8O1 3=8N2 4=5N1
  logic [4:0]      tx_v, done_v, busy_v, full_v, ovf_v;
  logic [4:0][2:0] cnt_v;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data), .ovf_clr(ovf_clr),
    .TX(tx_v[0]), .tx_done(done_v[0]), .busy(busy_v[0]), .full(full_v[0]),
    .count(cnt_v[0]), .overflow(ovf_v[0]));

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data), .ovf_clr(ovf_clr),
    .TX(tx_v[1]), .tx_done(done_v[1]), .busy(busy_v[1]), .full(full_v[1]),
    .count(cnt_v[1]), .overflow(ovf_v[1]));

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data), .ovf_clr(ovf_clr),
    .TX(tx_v[2]), .tx_done(done_v[2]), .busy(busy_v[2]), .full(full_v[2]),
    .count(cnt_v[2]), .overflow(ovf_v[2]));

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_8n2 (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data), .ovf_clr(ovf_clr),
    .TX(tx_v[3]), .tx_done(done_v[3]), .busy(busy_v[3]), .full(full_v[3]),
    .count(cnt_v[3]), .overflow(ovf_v[3]));

  uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_5n1 (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data[4:0]), .ovf_clr(ovf_clr),
    .TX(tx_v[4]), .tx_done(done_v[4]), .busy(busy_v[4]), .full(full_v[4]),
    .count(cnt_v[4]), .overflow(ovf_v[4]));

  typedef struct {
    int          inst;
    logic [7:0]  data;
    int          nbits;  // start + data + parity + stop bits
    logic [11:0] seq;    // expected line bits, bit 0 = start bit
    string       name;
  } frame_vec_t;

  frame_vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    trmt    = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    int         len, inst, early, pulses, gap, bad;
    logic       seen_low;

    vecs[0] = '{0, 8'hA5, 10, 12'b00_1101001010, "8n1_a5"};
    vecs[1] = '{1, 8'h07, 11, 12'b0_11000001110, "8e1_07"};
    vecs[2] = '{2, 8'h07, 11, 12'b0_10000001110, "8o1_07"};
    vecs[3] = '{3, 8'h3C, 11, 12'b0_11001111000, "8n2_3c"};
    vecs[4] = '{4, 8'hF3, 7,  12'b00000_1100110, "5n1_13"};
    vecs[5] = '{0, 8'hFF, 10, 12'b00_1111111110, "8n1_ff"};
    vecs[6] = '{0, 8'h00, 10, 12'b00_1000000000, "8n1_00"};

    // Reset state
    rst = 1'b1; trmt = 1'b0; ovf_clr = 1'b0; tx_data = 8'h00;
    #1;
    check("rst_tx_all", 32'(tx_v), 32'h1F);
    check("rst_done", 32'(done_v[0]), 0);
    check("rst_busy", 32'(busy_v[0]), 0);
    check("rst_full", 32'(full_v[0]), 0);
    check("rst_count", 32'(cnt_v[0]), 0);
    check("rst_ovf", 32'(ovf_v[0]), 0);

    // Single frames from the vector table
    for (int v = 0; v < 7; v++) begin
      inst = vecs[v].inst;
      len  = vecs[v].nbits * CPB;
      do_reset();
      trmt    = 1'b1;
      tx_data = vecs[v].data;
      @(posedge clk); #1;
      check({vecs[v].name, "_hold"}, 32'(tx_v[inst]), 1);
      @(negedge clk);
      trmt = 1'b0;
      @(posedge clk); #1;
      check({vecs[v].name, "_fall"}, 32'(tx_v[inst]), 0);
      early = 0;
      for (int c = 0; c < len; c++) begin
        if (c > 0) begin
          @(posedge clk); #1;
        end
        if (c % CPB == CPB/2)
          check($sformatf("%s_bit%0d", vecs[v].name, c / CPB), 32'(tx_v[inst]),
                32'(vecs[v].seq[c / CPB]));
        if (c == len - 1) begin
          check({vecs[v].name, "_done"}, 32'(done_v[inst]), 1);
          check({vecs[v].name, "_busy_end"}, 32'(busy_v[inst]), 1);
        end else if (done_v[inst]) begin
          early++;
        end
      end
      check({vecs[v].name, "_done_early"}, 32'(early), 0);
      @(posedge clk); #1;
      check({vecs[v].name, "_busy_drop"}, 32'(busy_v[inst]), 0);
      check({vecs[v].name, "_done_clr"}, 32'(done_v[inst]), 0);
      check({vecs[v].name, "_idle_tx"}, 32'(tx_v[inst]), 1);
    end

    // FIFO fill, overflow drop and back-to-back frames (8N1)
    do_reset();
    trmt    = 1'b1;
    tx_data = 8'h11;
    pulses  = 0;
    rx      = 8'h00;
    for (int e = 1; e <= 803; e++) begin
      int c, f, p, b;
      @(posedge clk); #1;
      c = e - 2;
      if (done_v[0]) pulses++;
      if (e == 2) check("fifo_pushpop_count", 32'(cnt_v[0]), 1);
      if (e == 4) check("fifo_full_early", 32'(full_v[0]), 0);
      if (e == 5) begin
        check("fifo_full", 32'(full_v[0]), 1);
        check("fifo_count4", 32'(cnt_v[0]), 4);
        check("fifo_ovf_pre", 32'(ovf_v[0]), 0);
      end
      if (e == 6) begin
        check("fifo_ovf_set", 32'(ovf_v[0]), 1);
        check("fifo_count_drop", 32'(cnt_v[0]), 4);
      end
      if (c >= 0 && c < 800) begin
        f = c / 160;
        p = c % 160;
        b = p / CPB;
        if (p % CPB == CPB/2) begin
          if (b == 0) check($sformatf("b2b_start%0d", f), 32'(tx_v[0]), 0);
          else if (b <= 8) rx[b-1] = tx_v[0];
        end
        if (p == 0 && c > 0) begin
          check($sformatf("b2b_nogap%0d", f), 32'(tx_v[0]), 0);
          check($sformatf("b2b_busy%0d", f), 32'(busy_v[0]), 1);
        end
        if (p == 159) begin
          check($sformatf("b2b_done%0d", f), 32'(done_v[0]), 1);
          check($sformatf("b2b_data%0d", f), 32'(rx), 32'(8'h11 + 8'(f)));
        end
      end
      if (c == 800) begin
        check("b2b_final_busy", 32'(busy_v[0]), 0);
        check("b2b_final_tx", 32'(tx_v[0]), 1);
      end
      @(negedge clk);
      if (e < 6) tx_data = 8'h11 + 8'(e);
      else       trmt = 1'b0;
    end
    check("b2b_pulses", 32'(pulses), 5);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    check("ovf_clr", 32'(ovf_v[0]), 0);
    @(negedge clk);
    ovf_clr = 1'b0;

    // Overflow event beats a simultaneous clear
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      trmt    = (e != 7);
      ovf_clr = (e == 6 || e == 7);
      tx_data = 8'h40 + 8'(e);
      @(posedge clk); #1;
      if (e == 6) check("ovf_wins_clr", 32'(ovf_v[0]), 1);
      if (e == 7) check("ovf_clr_alone", 32'(ovf_v[0]), 0);
      if (e == 8) begin
        check("ovf_reset_again", 32'(ovf_v[0]), 1);
        check("ovf_count_hold", 32'(cnt_v[0]), 4);
      end
      @(negedge clk);
    end
    trmt = 1'b0; ovf_clr = 1'b0;

    // Two stop bits: 32 high clocks between last data bit and next start bit
    do_reset();
    trmt    = 1'b1;
    tx_data = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'h81;
    @(posedge clk); #1;
    @(negedge clk);
    trmt     = 1'b0;
    gap      = 0;
    seen_low = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == 143) check("stop2_last_data", 32'(tx_v[3]), 0);
      if (c >= 144 && !seen_low) begin
        if (tx_v[3]) gap++;
        else seen_low = 1'b1;
      end
      if (c == 175) check("stop2_done", 32'(done_v[3]), 1);
      if (c == 176) begin
        check("stop2_next_start", 32'(tx_v[3]), 0);
        check("stop2_busy", 32'(busy_v[3]), 1);
      end
      if (c == 200) check("stop2_next_bit0", 32'(tx_v[3]), 1);
    end
    check("stop2_gap", 32'(gap), 32);

    // Reset during data bit 3 aborts the frame and empties the FIFO
    do_reset();
    trmt    = 1'b1;
    tx_data = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'h3C;
    @(posedge clk); #1;
    @(negedge clk);
    trmt = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
    end
    check("abort_mid_bit3", 32'(tx_v[0]), 0);
    check("abort_pre_count", 32'(cnt_v[0]), 1);
    rst = 1'b1;
    #1;
    check("abort_tx", 32'(tx_v[0]), 1);
    check("abort_busy", 32'(busy_v[0]), 0);
    check("abort_count", 32'(cnt_v[0]), 0);
    check("abort_done", 32'(done_v[0]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
    end
    check("abort_no_resume", 32'(bad), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
